// File: rtl/lwe_pkg.sv
// lwe_pkg: shared defaults, derived constants, word types and FSM states for the LWE decryptor.
package lwe_pkg;
    localparam int PW = 6;
    localparam int CW = 10;
    localparam int DIMENSION = 10;
    localparam int LANES = 2;
    localparam int NOISE_BOUND = 6;
    localparam int S = CW - PW;
    localparam int BEATS = DIMENSION / LANES;
    localparam int HALF = 2 ** (S - 1);
    typedef logic [CW-1:0] ct_word_t;
    typedef logic [PW-1:0] pt_word_t;
    typedef enum logic [1:0] {ACCUM, B_WAIT, DONE} state_t;
endpackage

// File: rtl/lwe_dot_lanes.sv
// lwe_dot_lanes: combinational sum over all lanes of a*s, truncated to the ciphertext modulus.
module lwe_dot_lanes #(
    parameter int LANES = 2,
    parameter int CW = 10
) (
    input  logic [LANES*CW-1:0] a_i,
    input  logic [LANES*CW-1:0] s_i,
    output logic [CW-1:0]       dot_o
);
    always_comb begin
        dot_o = '0;
        for (int k = 0; k < LANES; k++)
            dot_o = dot_o + a_i[k*CW +: CW] * s_i[k*CW +: CW];
    end
endmodule

// File: rtl/lwe_decrypt_stream.sv
// lwe_decrypt_stream: streaming LWE decryptor; accumulates <a,s> over the beats, then
// rounds (b - <a,s>) to a plaintext and flags large residual noise.
module lwe_decrypt_stream
    import lwe_pkg::*;
#(
    parameter int PLAINTEXT_WIDTH = PW,
    parameter int CIPHERTEXT_WIDTH = CW,
    parameter int DIMENSION = lwe_pkg::DIMENSION,
    parameter int LANES = lwe_pkg::LANES,
    parameter int NOISE_BOUND = lwe_pkg::NOISE_BOUND
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               clear,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [LANES*CIPHERTEXT_WIDTH-1:0]  in_a,
    input  logic [LANES*CIPHERTEXT_WIDTH-1:0]  in_s,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [PLAINTEXT_WIDTH-1:0]         out_data,
    output logic                               out_noisy
);
    localparam int W = CIPHERTEXT_WIDTH;
    localparam int SH = CIPHERTEXT_WIDTH - PLAINTEXT_WIDTH;
    localparam int NB = DIMENSION / LANES;
    localparam int CNTW = $clog2(NB + 1);

    state_t state_q, state_d;
    logic [W-1:0] acc_q, acc_d, dot, diff, rnd;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic ov_q, ov_d, noisy_q, noisy_d, last;
    logic [PLAINTEXT_WIDTH-1:0] data_q, data_d;
    logic [SH-1:0] e, mag;

    lwe_dot_lanes #(.LANES(LANES), .CW(W)) u_dot (.a_i(in_a), .s_i(in_s), .dot_o(dot));

    // Rounding adds half a plaintext step before the shift, so diff near q wraps to 0.
    assign diff = in_a[W-1:0] - acc_q;
    assign rnd = diff + W'(2 ** (SH - 1));
    assign e = diff[SH-1:0];
    assign mag = e[SH-1] ? -e : e;
    assign last = cnt_q == CNTW'(NB - 1);
    assign in_ready = state_q != DONE;
    assign out_valid = ov_q;
    assign out_data = data_q;
    assign out_noisy = noisy_q;

    always_comb begin
        state_d = state_q;
        acc_d = acc_q;
        cnt_d = cnt_q;
        ov_d = ov_q;
        data_d = data_q;
        noisy_d = noisy_q;
        if (clear) begin
            state_d = ACCUM;
            acc_d = '0;
            cnt_d = '0;
            ov_d = 1'b0;
        end else begin
            case (state_q)
                ACCUM: if (in_valid) begin
                    acc_d = acc_q + dot;
                    cnt_d = last ? '0 : cnt_q + CNTW'(1);
                    state_d = last ? B_WAIT : ACCUM;
                end
                B_WAIT: if (in_valid) begin
                    data_d = rnd[W-1:SH];
                    noisy_d = {1'b0, mag} >= (SH + 1)'(NOISE_BOUND);
                    acc_d = '0;
                    ov_d = 1'b1;
                    state_d = DONE;
                end
                DONE: if (out_ready) begin
                    ov_d = 1'b0;
                    state_d = ACCUM;
                end
                default: state_d = ACCUM;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ACCUM;
            acc_q <= '0;
            cnt_q <= '0;
            ov_q <= 1'b0;
            data_q <= '0;
            noisy_q <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q <= acc_d;
            cnt_q <= cnt_d;
            ov_q <= ov_d;
            data_q <= data_d;
            noisy_q <= noisy_d;
        end
    end
endmodule

// File: tb/tb_lwe_decrypt_stream.sv
// tb_lwe_decrypt_stream: directed vectors with hand-computed plaintexts for the LWE decryptor.
module tb_lwe_decrypt_stream;
    localparam int CW = 10;
    localparam int PW = 6;
    localparam int L = 2;

    logic clk = 1'b0, rst_n = 1'b0, clear = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic in_ready, out_valid, out_noisy;
    logic [L*CW-1:0] in_a = '0, in_s = '0;
    logic [PW-1:0] out_data;
    int checks = 0, passed = 0;

    always #5 clk = ~clk;

    lwe_decrypt_stream dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_s(in_s), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_noisy(out_noisy)
    );

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [CW-1:0] a0, s0, a1, s1);
        in_valid = 1'b1;
        in_a = {a1, a0};
        in_s = {s1, s0};
        step();
        in_valid = 1'b0;
    endtask

    // First beat carries the given pairs; remaining beats repeat them when all_beats, else zero.
    task automatic feed(input string tag, input logic [CW-1:0] a0, s0, a1, s1, input bit all_beats,
                        input logic [CW-1:0] b, input int exp_d, input int exp_n);
        for (int i = 0; i < 5; i++)
            if (i == 0 || all_beats) beat(a0, s0, a1, s1);
            else beat('0, '0, '0, '0);
        check({tag, " valid before b"}, out_valid, 0);
        beat(b, 10'd77, 10'd321, 10'd55);
        check({tag, " valid"}, out_valid, 1);
        check({tag, " data"}, out_data, exp_d);
        check({tag, " noisy"}, out_noisy, exp_n);
        check({tag, " in_ready done"}, in_ready, 0);
    endtask

    task automatic pop(input string tag);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check({tag, " valid after pop"}, out_valid, 0);
        check({tag, " in_ready after pop"}, in_ready, 1);
    endtask

    initial begin
        step();
        step();
        rst_n = 1'b1;
        step();
        check("reset valid", out_valid, 0);
        check("reset data", out_data, 0);
        check("reset noisy", out_noisy, 0);
        check("reset in_ready", in_ready, 1);

        feed("t1 s=0", 10'd123, 10'd0, 10'd456, 10'd0, 1'b1, 10'd80, 5, 0);
        pop("t1");
        feed("t2 ones", 10'd1, 10'd1, 10'd1, 10'd1, 1'b1, 10'd93, 5, 0);
        pop("t2");
        feed("t3 wrap63", 10'd4, 10'd4, 10'd0, 10'd0, 1'b0, 10'd0, 63, 0);
        pop("t3a");
        feed("t3 wrap0", 10'd2, 10'd2, 10'd0, 10'd0, 1'b0, 10'd0, 0, 0);
        pop("t3b");
        feed("t4 e=6", 10'd0, 10'd0, 10'd0, 10'd0, 1'b0, 10'd86, 5, 1);
        pop("t4a");
        feed("t4 e=5", 10'd0, 10'd0, 10'd0, 10'd0, 1'b0, 10'd85, 5, 0);
        pop("t4b");
        feed("t4 e=-6", 10'd0, 10'd0, 10'd0, 10'd0, 1'b0, 10'd90, 6, 1);
        pop("t4c");
        feed("t4 half", 10'd0, 10'd0, 10'd0, 10'd0, 1'b0, 10'd88, 6, 1);
        pop("t4d");
        // 1000*1000 + 500*3 = 28 mod 1024, so b=108 leaves diff 80
        feed("lanes wrap", 10'd1000, 10'd1000, 10'd500, 10'd3, 1'b0, 10'd108, 5, 0);
        pop("lanes");

        feed("t5 bp", 10'd9, 10'd0, 10'd9, 10'd0, 1'b1, 10'd80, 5, 0);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_a = {10'd1, 10'd1};
            in_s = {10'd1, 10'd1};
            step();
            check("t5 in_ready held", in_ready, 0);
            check("t5 valid held", out_valid, 1);
            check("t5 data held", out_data, 5);
        end
        in_valid = 1'b0;
        pop("t5");
        feed("t5 next", 10'd1, 10'd1, 10'd1, 10'd1, 1'b1, 10'd93, 5, 0);
        pop("t5 next");

        for (int i = 0; i < 3; i++) beat(10'd7, 10'd9, 10'd3, 10'd5);
        in_valid = 1'b1;
        clear = 1'b1;
        step();
        clear = 1'b0;
        in_valid = 1'b0;
        check("t6 clear valid", out_valid, 0);
        feed("t6 after clear", 10'd1, 10'd1, 10'd1, 10'd1, 1'b1, 10'd93, 5, 0);
        clear = 1'b1;
        step();
        clear = 1'b0;
        check("t6 clear drops result", out_valid, 0);
        check("t6 clear in_ready", in_ready, 1);

        feed("t6 pre-reset", 10'd0, 10'd0, 10'd0, 10'd0, 1'b0, 10'd86, 5, 1);
        rst_n = 1'b0;
        #1;
        check("t6 async reset valid", out_valid, 0);
        check("t6 async reset data", out_data, 0);
        check("t6 async reset in_ready", in_ready, 1);
        step();
        rst_n = 1'b1;
        feed("t6 after reset", 10'd1, 10'd1, 10'd1, 10'd1, 1'b1, 10'd93, 5, 0);
        pop("t6 end");

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
